// File: rtl/cpu_pkg.sv
// Shared decode definitions: widths, instruction field positions and
// the opcode flag decoder used by the decode stage.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int SEL_W  = 3;
  localparam int OPC_W  = 5;

  // Instruction field bit positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int RS_MSB  = 10;
  localparam int RS_LSB  = 8;
  localparam int RT_MSB  = 7;
  localparam int RT_LSB  = 5;
  localparam int RD_MSB  = 4;
  localparam int RD_LSB  = 2;
  localparam int IMM_MSB = 4;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  localparam logic [OPC_W-1:0] OPC_ILLEGAL = 5'b11111;

  typedef struct packed {
    logic uses_rt;
    logic writes_rd;
    logic illegal;
  } dec_flags_t;

  // opcode[4] marks a second register source; opcode[4:3]==2'b11 has no destination.
  function automatic dec_flags_t decode_flags(input logic [OPC_W-1:0] opc);
    dec_flags_t f;
    f.uses_rt   = opc[4];
    f.writes_rd = ~(opc[4] & opc[3]);
    f.illegal   = (opc == OPC_ILLEGAL);
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
    return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set when a
// writer issues and cleared by writeback (clr_a) or by a squash (clr_b).
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [SEL_W-1:0] set_sel,
  input  logic             clr_a,
  input  logic [SEL_W-1:0] clr_a_sel,
  input  logic             clr_b,
  input  logic [SEL_W-1:0] clr_b_sel,
  output logic [NREG-1:0]  busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clears first, set last: a clear of a non-busy register can never undo a new set.
  always_comb begin
    busy_d = busy_q;
    if (clr_a) busy_d[clr_a_sel] = 1'b0;
    if (clr_b) busy_d[clr_b_sel] = 1'b0;
    if (set)   busy_d[set_sel]   = 1'b1;
  end

  // Busy vector register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field extraction, RAW/WAW hazard detection against the busy
// scoreboard, and the ID/EX pipeline register with valid/ready handshake.
// Optional feature: define CPU_WB_BYPASS_EN to forward the writeback value
// into the operands and drop the matching source hazard.
module decode_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              if_ready,
  // register file read
  output logic [SEL_W-1:0]  rd1_sel,
  output logic [SEL_W-1:0]  rd2_sel,
  input  logic [DATA_W-1:0] rd1_data,
  input  logic [DATA_W-1:0] rd2_data,
  // writeback observe
  input  logic              wb_write,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  // execute side
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OPC_W-1:0]  ex_opcode,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [SEL_W-1:0]  ex_dst,
  output logic              ex_wr,
  output logic [DATA_W-1:0] ex_pc,
  // control
  input  logic              flush,
  output logic              err_dec
);

  logic [OPC_W-1:0]  opc;
  logic [SEL_W-1:0]  rs, rt, rd;
  logic [DATA_W-1:0] imm;
  dec_flags_t        fl;
  logic [NREG-1:0]   busy;

  logic              haz_rs, haz_rt, haz_rd, hazard, issue;
  logic [DATA_W-1:0] opa, opb;

  logic              ex_valid_q, ex_valid_d;
  logic [OPC_W-1:0]  ex_opcode_q, ex_opcode_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [SEL_W-1:0]  ex_dst_q, ex_dst_d;
  logic              ex_wr_q, ex_wr_d;
  logic [DATA_W-1:0] ex_pc_q, ex_pc_d;
  logic              err_dec_q, err_dec_d;

  assign opc = if_instr[OPC_MSB:OPC_LSB];
  assign rs  = if_instr[RS_MSB:RS_LSB];
  assign rt  = if_instr[RT_MSB:RT_LSB];
  assign rd  = if_instr[RD_MSB:RD_LSB];
  assign imm = sext_imm(if_instr[IMM_MSB:IMM_LSB]);
  assign fl  = decode_flags(opc);

  assign rd1_sel = rs;
  assign rd2_sel = rt;

`ifndef CPU_WB_BYPASS_EN
  // Without forwarding the writeback value is never consumed here.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  // Hazard detection and operand selection (with optional writeback forwarding).
  always_comb begin
    haz_rd = fl.writes_rd & busy[rd];
`ifdef CPU_WB_BYPASS_EN
    haz_rs = busy[rs] & ~(wb_write & (wb_sel == rs));
    haz_rt = fl.uses_rt & busy[rt] & ~(wb_write & (wb_sel == rt));
    opa    = (wb_write & (wb_sel == rs)) ? wb_data : rd1_data;
    opb    = (wb_write & (wb_sel == rt)) ? wb_data : rd2_data;
`else
    haz_rs = busy[rs];
    haz_rt = fl.uses_rt & busy[rt];
    opa    = rd1_data;
    opb    = rd2_data;
`endif
    hazard = haz_rs | haz_rt | haz_rd;
  end

  assign if_ready = (~ex_valid_q | ex_ready) & ~hazard & ~flush;
  assign issue    = if_valid & if_ready;

  // ID/EX next state: load on issue, drop on flush or consumption, otherwise hold.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_opcode_d = ex_opcode_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_imm_d    = ex_imm_q;
    ex_dst_d    = ex_dst_q;
    ex_wr_d     = ex_wr_q;
    ex_pc_d     = ex_pc_q;
    err_dec_d   = 1'b0;
    if (issue) begin
      ex_valid_d  = 1'b1;
      ex_opcode_d = opc;
      ex_a_d      = opa;
      ex_b_d      = opb;
      ex_imm_d    = imm;
      ex_dst_d    = rd;
      ex_wr_d     = fl.writes_rd & ~fl.illegal;
      ex_pc_d     = if_pc;
      err_dec_d   = fl.illegal;
    end else if (flush | ex_ready) begin
      ex_valid_d  = 1'b0;
    end
  end

  // ID/EX register; reset clears the entry and its payload asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q  <= 1'b0;
      ex_opcode_q <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_imm_q    <= '0;
      ex_dst_q    <= '0;
      ex_wr_q     <= 1'b0;
      ex_pc_q     <= '0;
      err_dec_q   <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_opcode_q <= ex_opcode_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_imm_q    <= ex_imm_d;
      ex_dst_q    <= ex_dst_d;
      ex_wr_q     <= ex_wr_d;
      ex_pc_q     <= ex_pc_d;
      err_dec_q   <= err_dec_d;
    end
  end

  reg_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .set       (issue & fl.writes_rd & ~fl.illegal),
    .set_sel   (rd),
    .clr_a     (wb_write),
    .clr_a_sel (wb_sel),
    .clr_b     (flush & ex_valid_q & ex_wr_q),
    .clr_b_sel (ex_dst_q),
    .busy      (busy)
  );

  assign ex_valid  = ex_valid_q;
  assign ex_opcode = ex_opcode_q;
  assign ex_a      = ex_a_q;
  assign ex_b      = ex_b_q;
  assign ex_imm    = ex_imm_q;
  assign ex_dst    = ex_dst_q;
  assign ex_wr     = ex_wr_q;
  assign ex_pc     = ex_pc_q;
  assign err_dec   = err_dec_q;

endmodule
